// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the 5-stage pipeline.
// Covers the hazards bypassing cannot: load-use, taken-branch redirect and
// multi-cycle MUL/DIV occupancy of E.
// Optional feature macro: MDU_STALL_EN builds the MDU occupancy FSM and
// latency counter; without it mduStartE is ignored and MDU outputs stay 0.
module hazard_unit #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rdE,
  input  logic       MemReadE,
  input  logic       PCSrcE,
  input  logic       mduStartE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       mduBusy,
  output logic       mduDone
);

  logic lw_stall;
  logic mdu_stall;
  logic mdu_busy;
  logic mdu_done;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign lw_stall = MemReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

`ifdef MDU_STALL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Start cycle counts as the first held cycle, so BUSY loads LATENCY-2
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and MDU-side outputs; mduStartE is ignored outside IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_stall = 1'b0;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      IDLE: begin
        if (mduStartE) begin
          mdu_stall = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mdu_stall = 1'b1;
        mdu_busy  = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        mdu_busy  = 1'b1;
        mdu_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  localparam int unused_mdu_latency = MDU_LATENCY;
  localparam int unused_cnt_w       = CNT_W;
  logic unused_start;
  assign unused_start = mduStartE;
  assign mdu_stall    = 1'b0;
  assign mdu_busy     = 1'b0;
  assign mdu_done     = 1'b0;
`endif

  // Output combine; a held E register is never cleared, and reset zeroes all
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    mduBusy = 1'b0;
    mduDone = 1'b0;
    if (!reset) begin
      stallF  = lw_stall | mdu_stall;
      stallD  = lw_stall | mdu_stall;
      stallE  = mdu_stall;
      flushM  = mdu_stall;
      flushD  = PCSrcE & ~mdu_stall;
      flushE  = (lw_stall | PCSrcE) & ~mdu_stall;
      mduBusy = mdu_busy;
      mduDone = mdu_done;
    end
  end

endmodule
